// File: rtl/inchars12_rx_pkg.sv
// rtl/inchars12_rx_pkg.sv - shared simple serial I/O types, constants and helpers
package inchars12_rx_pkg;

    // Request FSM encoding shared with the character-output routines
    typedef enum logic [1:0] {
        READY   = 2'd0,
        INITS   = 2'd1,
        WAITING = 2'd2
    } req_state_e;

    // Byte receiver FSM encoding, mirror of the byte transmitter
    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_HOLD  = 3'd4
    } rx_state_e;

    localparam int CLK_HZ_DEFAULT = 100_000_000;
    localparam int BAUD_DEFAULT   = 115_200;
    localparam int MAX_CHARS      = 12;

    // Terminator ends a request early; fill matches the output routines' blank character
    localparam logic [7:0] TERM = 8'd13;
    localparam logic [7:0] FILL = 8'd126;

    // Clocks per bit; callers must keep this at 16 or more for mid-bit sampling
    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    localparam int DIV_DEFAULT = calc_div(CLK_HZ_DEFAULT, BAUD_DEFAULT);

    // Requested length is limited to the buffer depth
    function automatic logic [3:0] clamp_n(input logic [3:0] n);
        return (n > 4'(MAX_CHARS)) ? 4'(MAX_CHARS) : n;
    endfunction

endpackage

// File: rtl/inchars12_rx_inbyte115200_rx.sv
// rtl/inchars12_rx_inbyte115200_rx.sv - UART byte receiver with synchronizer and framing check
module inbyte115200_rx
    import inchars12_rx_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inchan,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          line_prev_q, line_prev_d;
    rx_state_e     state_q, state_d;
    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          byte_valid_q, byte_valid_d;
    logic          frame_err_q, frame_err_d;

    // Bit-level framing: find start edge, sample mid-bit, check stop bit
    always_comb begin
        sync1_d      = inchan;
        sync2_d      = sync1_q;
        line_prev_d  = sync2_q;
        state_d      = state_q;
        div_cnt_d    = div_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                div_cnt_d = '0;
                if (line_prev_q && !sync2_q) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (div_cnt_q == HALF_LAST) begin
                    div_cnt_d = '0;
                    bit_cnt_d = 4'd0;
                    // A line that is high again at mid start bit was only a glitch
                    state_d   = sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (div_cnt_q == BIT_LAST) begin
                    div_cnt_d = '0;
                    shift_d   = {sync2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (div_cnt_q == BIT_LAST) begin
                    div_cnt_d = '0;
                    if (sync2_q) begin
                        byte_valid_d = 1'b1;
                        state_d      = RX_IDLE;
                    end else begin
                        frame_err_d  = 1'b1;
                        state_d      = RX_HOLD;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            RX_HOLD: begin
                // Wait out a stuck-low line so it is not mistaken for a new start bit
                if (sync2_q) begin
                    state_d = RX_IDLE;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    // State registers; synchronizer resets to the idle-high line level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            line_prev_q  <= 1'b1;
            state_q      <= RX_IDLE;
            div_cnt_q    <= '0;
            bit_cnt_q    <= 4'd0;
            shift_q      <= 8'd0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            line_prev_q  <= line_prev_d;
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign byte_data  = shift_q;
    assign byte_valid = byte_valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: rtl/inchars12_rx.sv
// rtl/inchars12_rx.sv - receive up to 12 UART characters into a parallel buffer
module inchars12_rx
    import inchars12_rx_pkg::*;
#(
    parameter int CLK_HZ = CLK_HZ_DEFAULT,
    parameter int BAUD   = BAUD_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       inchan,
    input  logic [3:0] n,
    output logic [7:0] c0,
    output logic [7:0] c1,
    output logic [7:0] c2,
    output logic [7:0] c3,
    output logic [7:0] c4,
    output logic [7:0] c5,
    output logic [7:0] c6,
    output logic [7:0] c7,
    output logic [7:0] c8,
    output logic [7:0] c9,
    output logic [7:0] c10,
    output logic [7:0] c11,
    output logic [3:0] count,
    output logic       result,
    output logic       framing_err,
    output logic       result_ready
);

    localparam int DIV = calc_div(CLK_HZ, BAUD);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ferr;

    req_state_e state_q, state_d;
    logic [3:0] n_l_q, n_l_d;
    logic [3:0] count_q, count_d;
    logic       result_q, result_d;
    logic       ferr_q, ferr_d;
    logic [7:0] buf_q [MAX_CHARS];
    logic [7:0] buf_d [MAX_CHARS];

    inbyte115200_rx #(
        .DIV(DIV)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .inchan    (inchan),
        .byte_data (rx_byte),
        .byte_valid(rx_valid),
        .frame_err (rx_ferr)
    );

    // Request FSM: start always wins, then clear, then collect bytes until n_l or TERM
    always_comb begin
        state_d  = state_q;
        n_l_d    = n_l_q;
        count_d  = count_q;
        result_d = result_q;
        ferr_d   = ferr_q;
        buf_d    = buf_q;
        if (start) begin
            state_d = INITS;
            n_l_d   = clamp_n(n);
        end else begin
            case (state_q)
                READY: begin
                    state_d = READY;
                end
                INITS: begin
                    count_d = 4'd0;
                    ferr_d  = 1'b0;
                    for (int i = 0; i < MAX_CHARS; i++) begin
                        buf_d[i] = FILL;
                    end
                    if (n_l_q == 4'd0) begin
                        result_d = 1'b1;
                        state_d  = READY;
                    end else begin
                        result_d = 1'b0;
                        state_d  = WAITING;
                    end
                end
                WAITING: begin
                    if (rx_valid) begin
                        if (rx_byte == TERM) begin
                            result_d = 1'b0;
                            state_d  = READY;
                        end else begin
                            for (int i = 0; i < MAX_CHARS; i++) begin
                                if (count_q == 4'(i)) begin
                                    buf_d[i] = rx_byte;
                                end
                            end
                            count_d = count_q + 4'd1;
                            if (count_q + 4'd1 == n_l_q) begin
                                result_d = 1'b1;
                                state_d  = READY;
                            end
                        end
                    end else if (rx_ferr) begin
                        ferr_d = 1'b1;
                    end
                end
                default: begin
                    state_d = READY;
                end
            endcase
        end
    end

    // Request state, latched length, counters and character buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= READY;
            n_l_q    <= 4'd0;
            count_q  <= 4'd0;
            result_q <= 1'b0;
            ferr_q   <= 1'b0;
            for (int i = 0; i < MAX_CHARS; i++) begin
                buf_q[i] <= FILL;
            end
        end else begin
            state_q  <= state_d;
            n_l_q    <= n_l_d;
            count_q  <= count_d;
            result_q <= result_d;
            ferr_q   <= ferr_d;
            buf_q    <= buf_d;
        end
    end

    assign c0  = buf_q[0];
    assign c1  = buf_q[1];
    assign c2  = buf_q[2];
    assign c3  = buf_q[3];
    assign c4  = buf_q[4];
    assign c5  = buf_q[5];
    assign c6  = buf_q[6];
    assign c7  = buf_q[7];
    assign c8  = buf_q[8];
    assign c9  = buf_q[9];
    assign c10 = buf_q[10];
    assign c11 = buf_q[11];

    assign count        = count_q;
    assign result       = result_q;
    assign framing_err  = ferr_q;
    assign result_ready = (state_q == READY) & ~start;

endmodule

// File: doc/inchars12_rx.md
# inchars12_rx

Receive side of the simple serial I/O library. Captures up to 12 characters from the UART line at 115200 bps into a parallel buffer. Uses the same start / result / result_ready handshake as the character-output routines, so generated code can drive it the same way. Sits between the board's UART RX pin and the Bream-generated logic that consumes typed input.

## Interface

- CLK_HZ, 100000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bits per second.
- DIV, CLK_HZ/BAUD (868), clocks per bit. Derived; must be ≥ 16.
- TERM, 8'd13, terminator byte that ends reception early.
- FILL, 8'd126, value loaded into unused buffer slots.
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a request; it is sampled at every edge.
- inchan  in  1  UART RX line; asynchronous to clk; idles high.
- n  in  4  number of characters requested; latched on start; values above 12 are clamped to 12.
- c0 … c11  out  8 each  received characters, with c0 first.
- count  out  4  number of characters stored, 0..12.
- result  out  1  1 = n characters received; 0 = ended by TERM.
- framing_err  out  1  sticky flag; set when a stop bit is low; cleared by start.
- result_ready  out  1  request complete; equals (state == READY) & ~start.

## Operation

- Top FSM states: READY, INITS, WAITING.
- Reset puts the FSM in READY and sets result=0, count=0, framing_err=0, c0..c11=FILL. result_ready=1 while rst_n is high and start is low.
- start in any state goes to INITS. This covers a restart mid-reception: the partial buffer is discarded.
- INITS:
  - latch n_l = min(n,12); count←0; c0..c11←FILL; framing_err←0.
  - If n_l==0, set result←1 and go to READY; otherwise go to WAITING.
- WAITING, on byte_valid from the sub-module:
  - byte==TERM: result←0, go to READY. TERM is not stored and count is unchanged.
  - otherwise: c[count]←byte and count←count+1. If count+1==n_l, result←1 and go to READY.
- WAITING, on frame_err pulse: framing_err←1, no byte is stored, and the FSM stays in WAITING.
- Bytes that complete while in READY or INITS are discarded.
- Outputs hold their values in READY until the next start.
- count is a 4-bit unsigned value and never exceeds n_l. There is no wrap.

## Timing

- RX sub-module states: IDLE, START, DATA, STOP, HOLD. inchan passes through a 2-flop synchronizer, adding 2 cycles of latency.
- IDLE→START on a synchronized falling edge.
- START waits DIV/2 cycles, then re-samples:
  - high means a glitch; return to IDLE.
  - low means DATA.
- DATA takes 8 samples spaced DIV cycles apart, LSB first.
- STOP samples once after a further DIV cycles:
  - high: byte_valid pulses for 1 cycle, then IDLE.
  - low: frame_err pulses for 1 cycle, then HOLD.
- HOLD waits until the synchronized line is high, then goes to IDLE.
- The bit counter is 4 bits; the divider counter is $clog2(DIV) bits.
- byte_valid is consumed on the same edge it is high. The top FSM leaves WAITING on that edge, so result_ready rises 1 cycle after the stop-bit sample of the final byte.
- start and byte_valid on the same edge: start wins and the byte is dropped.
- rst_n low mid-frame: the sub-module returns to IDLE immediately; the current frame is lost.

## Structure

- The shared simpleio package holds:
  - the state encodings (READY=0, INITS=1, WAITING=2; RX IDLE..HOLD);
  - the DIV computation;
  - TERM and FILL.
- The package must stay consistent with the output routines' 8'd126 fill.
- One sub-module: inbyte115200_rx, containing the synchronizer, the bit FSM, and the byte_valid/frame_err outputs. It is the mirror of the byte transmitter.
- The top level holds only the request FSM and the 12×8 buffer.

## Test plan

- Reset, then start with n=3 and send "ABC" (0x41,0x42,0x43) → c0..c2=41,42,43; c3..c11=0x7E; count=3; result=1. result_ready rises 1 cycle after the third stop sample.
- n=12, send "HI" then 0x0D → count=2, result=0, c2=0x7E.
- n=0 → result_ready returns within 2 cycles of start; result=1, count=0, no line activity needed.
- n=15, send 14 bytes → only the first 12 are stored; count=12, result=1; the remaining bytes are ignored.
- n=2, send 0x55 with the stop bit forced low, then 0x31, 0x32 → framing_err=1, c0=0x31, c1=0x32, result=1.
- Assert start again after 1 byte of n=4, and separately assert rst_n low mid-frame → the buffer is re-filled with 0x7E and count=0. A 200 ns low glitch on inchan produces no byte.
